// File: rtl/led_fade_if.sv
// Pattern/drive bundle between the LED pattern decoder and the fade driver.
// The decoder side (master) supplies targets and freeze; the driver side
// (slave) returns the pin drive and status flags.
interface led_fade_if #(
    parameter int N_LEDS = 6
);
    logic [N_LEDS-1:0] pattern;
    logic              freeze;
    logic [N_LEDS-1:0] leds;
    logic              period_start;
    logic              all_settled;

    modport master (
        output pattern,
        output freeze,
        input  leds,
        input  period_start,
        input  all_settled
    );

    modport slave (
        input  pattern,
        input  freeze,
        output leds,
        output period_start,
        output all_settled
    );
endinterface

// File: rtl/led_fade_driver.sv
// LED fade driver: per-LED brightness levels ramp toward the on/off target
// on a prescaled tick; levels are latched at the PWM period boundary and
// compared against a free-running PWM counter to drive the pins.
module led_fade_driver #(
    parameter int N_LEDS     = 6,
    parameter int PWM_BITS   = 8,
    parameter int RAMP_DIV   = 27000,
    parameter int STEP       = 8,
    parameter int ACTIVE_LOW = 1
) (
    input  logic      clk,
    input  logic      rst,
    led_fade_if.slave bus
);
    localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PWM_BITS-1:0]        LVL_MAX = '1;
    localparam logic signed [PWM_BITS+1:0] SMAX    = $signed({2'b00, LVL_MAX});
    localparam logic signed [PWM_BITS+1:0] SSTEP   = (PWM_BITS+2)'(STEP);
    localparam logic [N_LEDS-1:0]          POL     = {N_LEDS{(ACTIVE_LOW != 0)}};
    localparam logic [DIV_W-1:0]           DIV_LAST = DIV_W'(RAMP_DIV - 1);

    // One ramp step with two guard bits so neither direction can wrap;
    // the result is clamped back into 0..MAX.
    function automatic logic [PWM_BITS-1:0] ramp_sat(
        input logic [PWM_BITS-1:0] cur,
        input logic                up
    );
        logic signed [PWM_BITS+1:0] sum;
        sum = $signed({2'b00, cur}) + (up ? SSTEP : -SSTEP);
        if (sum > SMAX)
            return LVL_MAX;
        else if (sum < 0)
            return '0;
        else
            return sum[PWM_BITS-1:0];
    endfunction

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [DIV_W-1:0]    presc;
    logic                ramp_tick;
    logic [PWM_BITS-1:0] level  [N_LEDS];
    logic [PWM_BITS-1:0] duty_q [N_LEDS];
    logic [N_LEDS-1:0]   lit;
    logic [N_LEDS-1:0]   at_target;
    logic [N_LEDS-1:0]   leds_p1;
    logic                period_start_p1;
    logic                all_settled_p1;

    assign ramp_tick = (presc == DIV_LAST);

    // Per-LED lit decision and settle status from the current state.
    always_comb begin
        lit       = '0;
        at_target = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            lit[i]       = (duty_q[i] == LVL_MAX) || (pwm_cnt < duty_q[i]);
            at_target[i] = (level[i] == (bus.pattern[i] ? LVL_MAX : '0));
        end
    end

    // Counters, ramp levels, period-boundary duty latch and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pwm_cnt         <= '0;
            presc           <= '0;
            leds_p1         <= POL;
            period_start_p1 <= 1'b0;
            all_settled_p1  <= 1'b0;
            for (int i = 0; i < N_LEDS; i++) begin
                level[i]  <= '0;
                duty_q[i] <= '0;
            end
        end else begin
            pwm_cnt         <= pwm_cnt + 1'b1;
            presc           <= ramp_tick ? '0 : presc + 1'b1;
            // stage p1: pin drive and flags, one cycle behind pwm_cnt
            leds_p1         <= lit ^ POL;
            period_start_p1 <= (pwm_cnt == '0);
            all_settled_p1  <= &at_target;
            for (int i = 0; i < N_LEDS; i++) begin
                if (pwm_cnt == LVL_MAX)
                    duty_q[i] <= level[i];
                if (ramp_tick && !bus.freeze)
                    level[i] <= ramp_sat(level[i], bus.pattern[i]);
            end
        end
    end

    assign bus.leds         = leds_p1;
    assign bus.period_start = period_start_p1;
    assign bus.all_settled  = all_settled_p1;
endmodule
